pio_port: RTL and testbench
===========================

# pio_port

Parametrised Avalon-MM parallel I/O slave for board LEDs, switches and keys in the NIOS system. It replaces the fixed 10-bit write-only output register with a configurable-width block that provides:
- an output register with atomic bit set/clear;
- a synchronised input port with per-bit edge capture;
- a maskable level interrupt;
- registered readback.

It sits on the system interconnect between the NIOS data master and the board pins.

## Interface
Parameters:
- DATA_WIDTH, 10: width of out_port, in_port and all registers.
- RESET_VALUE, 0: out_port value after reset.
- EDGE_TYPE, 0: captured edge type. 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: input synchroniser depth. Legal range is 2 to 4.

Ports:
- clk  in  1  system clock. All logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- read_n  in  1  active-low read strobe, qualified by chipselect.
- writedata  in  DATA_WIDTH  write data.
- readdata  out  DATA_WIDTH  registered read data.
- in_port  in  DATA_WIDTH  asynchronous board inputs.
- out_port  out  DATA_WIDTH  output register contents.
- irq  out  1  level interrupt request.

One clock; reset is synchronous and active-high.

## Operation
Register map (word addresses):
- 0 DATA: write sets out_reg = writedata. Read returns in_sync, the synchronised inputs.
- 1 OUTSET: write sets out_reg |= writedata. Read returns out_reg.
- 2 OUTCLR: write sets out_reg &= ~writedata. Read returns out_reg.
- 3 IRQ_MASK: read/write, DATA_WIDTH bits.
- 4 EDGE_CAP: read returns the capture bits. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- 5 to 7: reserved. Reads return 0; writes are ignored.

Strobes:
- wr = chipselect & ~write_n.
- rd = chipselect & ~read_n & ~wr. Write wins if both strobes are low.

Input path:
- in_port passes through a chain of SYNC_STAGES flops, giving in_sync.
- in_prev holds in_sync delayed by one cycle.
- edge = in_sync & ~in_prev for rising, ~in_sync & in_prev for falling, in_sync ^ in_prev for any.
- Capture update: cap <= (cap & ~clr) | edge, where clr = writedata on an EDGE_CAP write and 0 otherwise.
- If a new edge and a clear hit the same bit in the same cycle, the edge wins and the bit stays 1.

Interrupt:
- irq = |(cap & mask), combinational from registers.

Reset, while reset is high:
- out_reg = RESET_VALUE.
- mask = 0.
- cap = 0.
- readdata = 0.
- The synchroniser keeps sampling and in_prev keeps tracking in_sync. As a result, no spurious edge is captured at reset release if reset was held for at least SYNC_STAGES+1 cycles.
- Reset asserted mid-operation takes effect at the next edge and overrides any concurrent access.

## Timing
- Write latency: the new out_reg, mask or cap value is visible immediately after the clock edge that samples wr.
- Read latency: 1 cycle. readdata is loaded at the edge that samples rd and holds that value until the next rd or reset.
- Reads return the register values from before the edge, so a read concurrent with a write or a capture returns the old value.
- Input latency: if in_port changes before edge E0, in_sync shows the change after edge E(SYNC_STAGES-1). The cap bit, and irq if the bit is masked in, are set after edge E(SYNC_STAGES).
- A pulse must be stable for at least 2 cycles to be guaranteed captured.
- No wait states; the slave never stalls.

## Test plan
- Reset value: RESET_VALUE=10'h155, hold reset 4 cycles -> out_port=10'h155, irq=0, readdata=0. Then read addresses 1 and 3 -> 10'h155 and 0, each one cycle after its strobe.
- Set/clear: write 0 <- 10'h0F0, write 1 <- 10'h003, write 2 <- 10'h030 -> out_port reads 10'h0F0, then 10'h0F3, then 10'h0C3, each change the cycle after its write.
- Rising edge with SYNC_STAGES=2: mask=10'h001, in_port[0] goes 0->1 before E0 -> cap[0]=1 and irq=1 after E2. Read 4 -> 10'h001. Write 4 <- 10'h001 -> irq=0 the next cycle.
- Clear/edge collision: a new rising edge on bit 3 arrives in the same cycle as a write 4 <- 10'h008 -> cap[3] stays 1.
- Masking and EDGE_TYPE=2: mask=0, toggle in_port[5] twice -> cap[5]=1 and irq=0. Set mask=10'h020 -> irq=1 the next cycle.
- Reserved and reset-release behaviour: write 6 <- 10'h3FF -> no register changes, read 6 -> 0. Hold in_port=10'h3FF high through reset and release -> cap stays 0.

Source files
------------

// File: rtl/pio_port.sv
// Avalon-MM parallel I/O slave: output register with atomic set/clear, synchronised
// inputs with per-bit edge capture, maskable level interrupt and registered readback.

module pio_lane #(
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic in_bit,
   input  logic clr,
   output logic sync_bit,
   output logic cap_bit
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_det;

   // The synchroniser and edge history keep running through reset so that a
   // long enough reset leaves no stale edge behind at release.
   always_ff @(posedge clk) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
      prev_q <= sync_q[SYNC_STAGES-1];
   end

   assign sync_bit = sync_q[SYNC_STAGES-1];

   always_comb begin
      edge_det = 1'b0;
      if (EDGE_TYPE == 0)
         edge_det = sync_bit & ~prev_q;
      else if (EDGE_TYPE == 1)
         edge_det = ~sync_bit & prev_q;
      else
         edge_det = sync_bit ^ prev_q;
   end

   // A fresh edge beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset)
         cap_bit <= 1'b0;
      else
         cap_bit <= (cap_bit & ~clr) | edge_det;
   end

endmodule

module pio_port #(
   parameter int                    DATA_WIDTH  = 10,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int                    EDGE_TYPE   = 0,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic                  read_n,
   input  logic [DATA_WIDTH-1:0] writedata,
   output logic [DATA_WIDTH-1:0] readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  irq
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_OUTSET   = 3'd1;
   localparam logic [2:0] ADDR_OUTCLR   = 3'd2;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd4;

   logic                  wr, rd;
   logic [DATA_WIDTH-1:0] out_reg, mask, cap, in_sync, cap_clr, rd_mux;

   assign wr = chipselect & ~write_n;
   assign rd = chipselect & ~read_n & ~wr;

   assign cap_clr = (wr && address == ADDR_EDGE_CAP) ? writedata : '0;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
      pio_lane #(
         .EDGE_TYPE   (EDGE_TYPE),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .in_bit   (in_port[i]),
         .clr      (cap_clr[i]),
         .sync_bit (in_sync[i]),
         .cap_bit  (cap[i])
      );
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:                rd_mux = in_sync;
         ADDR_OUTSET, ADDR_OUTCLR: rd_mux = out_reg;
         ADDR_IRQ_MASK:            rd_mux = mask;
         ADDR_EDGE_CAP:            rd_mux = cap;
         default:                  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_reg  <= RESET_VALUE;
         mask     <= '0;
         readdata <= '0;
      end else begin
         if (wr) begin
            case (address)
               ADDR_DATA:     out_reg <= writedata;
               ADDR_OUTSET:   out_reg <= out_reg | writedata;
               ADDR_OUTCLR:   out_reg <= out_reg & ~writedata;
               ADDR_IRQ_MASK: mask    <= writedata;
               default:       ;
            endcase
         end
         if (rd)
            readdata <= rd_mux;
      end
   end

   assign out_port = out_reg;
   assign irq      = |(cap & mask);

endmodule

// File: tb/tb_pio_port.sv
// Bench for pio_port: a rising-edge and an any-edge instance share one bus and
// are checked by directed scenarios plus a random run against a behavioural model.

module tb_pio_port;

   localparam int W = 10;
   localparam int S = 2;
   localparam logic [W-1:0] RV = 10'h155;

   logic         clk = 1'b0;
   logic         reset;
   logic [2:0]   address;
   logic         chipselect, write_n, read_n;
   logic [W-1:0] writedata, in_port;
   logic [W-1:0] rdata0, out0, rdata2, out2;
   logic         irq0, irq2;

   int vectors = 0;
   int miscompares = 0;

   // model state
   logic [W-1:0] out_m, mask_m, cap0_m, cap2_m, rd0_m, rd2_m;
   logic [W-1:0] hist[$];

   always #5 clk = ~clk;

   pio_port #(.DATA_WIDTH(W), .RESET_VALUE(RV), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rdata0),
      .in_port(in_port), .out_port(out0), .irq(irq0));

   pio_port #(.DATA_WIDTH(W), .RESET_VALUE(RV), .EDGE_TYPE(2), .SYNC_STAGES(S)) dut2 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rdata2),
      .in_port(in_port), .out_port(out2), .irq(irq2));

   // One clock edge: hist[0] is the latest in_port sample, so the synchronised
   // value seen before this edge is the sample taken S-1 edges earlier.
   task automatic tick();
      logic [W-1:0] cur, prev, clr, e0, e2, m0, m2;
      logic wr, rd;
      @(posedge clk);
      cur  = hist[S-1];
      prev = hist[S];
      hist.push_front(in_port);
      void'(hist.pop_back());
      wr = chipselect && !write_n;
      rd = chipselect && !read_n && !wr;
      if (reset) begin
         out_m = RV; mask_m = '0; cap0_m = '0; cap2_m = '0; rd0_m = '0; rd2_m = '0;
      end else begin
         m0 = '0; m2 = '0;
         if (address == 3'd0) begin m0 = cur; m2 = cur; end
         else if (address == 3'd1 || address == 3'd2) begin m0 = out_m; m2 = out_m; end
         else if (address == 3'd3) begin m0 = mask_m; m2 = mask_m; end
         else if (address == 3'd4) begin m0 = cap0_m; m2 = cap2_m; end
         if (rd) begin rd0_m = m0; rd2_m = m2; end
         clr = (wr && address == 3'd4) ? writedata : '0;
         e0 = cur & ~prev;
         e2 = cur ^ prev;
         if (wr) begin
            if (address == 3'd0) out_m = writedata;
            else if (address == 3'd1) out_m = out_m | writedata;
            else if (address == 3'd2) out_m = out_m & ~writedata;
            else if (address == 3'd3) mask_m = writedata;
         end
         cap0_m = (cap0_m & ~clr) | e0;
         cap2_m = (cap2_m & ~clr) | e2;
      end
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [W-1:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      tick();
      chipselect = 1'b0; read_n = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
      address = '0; writedata = '0; in_port = '0;
      repeat (4) tick();
      vectors++; if (out0 !== 10'h155) begin miscompares++; $display("FAIL reset_out got %h exp 155", out0); end
      vectors++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b/%b exp 0", irq0, irq2); end
      vectors++; if (rdata0 !== '0) begin miscompares++; $display("FAIL reset_rdata got %h exp 000", rdata0); end
      reset = 1'b0;
      bus_read(3'd1);
      vectors++; if (rdata0 !== 10'h155) begin miscompares++; $display("FAIL read_out got %h exp 155", rdata0); end
      bus_read(3'd3);
      vectors++; if (rdata0 !== '0) begin miscompares++; $display("FAIL read_mask got %h exp 000", rdata0); end
   endtask

   task automatic test_set_clear();
      bus_write(3'd0, 10'h0F0);
      vectors++; if (out0 !== 10'h0F0) begin miscompares++; $display("FAIL write_data got %h exp 0F0", out0); end
      bus_write(3'd1, 10'h003);
      vectors++; if (out0 !== 10'h0F3) begin miscompares++; $display("FAIL outset got %h exp 0F3", out0); end
      bus_write(3'd2, 10'h030);
      vectors++; if (out0 !== 10'h0C3 || out2 !== 10'h0C3) begin miscompares++; $display("FAIL outclr got %h/%h exp 0C3", out0, out2); end
   endtask

   task automatic test_rising_edge();
      bus_write(3'd3, 10'h001);
      in_port[0] = 1'b1;
      tick();  // E0
      vectors++; if (irq0 !== 1'b0) begin miscompares++; $display("FAIL irq_e0 got %b exp 0", irq0); end
      tick();  // E1
      vectors++; if (irq0 !== 1'b0) begin miscompares++; $display("FAIL irq_e1 got %b exp 0", irq0); end
      tick();  // E2
      vectors++; if (irq0 !== 1'b1 || irq2 !== 1'b1) begin miscompares++; $display("FAIL irq_e2 got %b/%b exp 1", irq0, irq2); end
      bus_read(3'd4);
      vectors++; if (rdata0 !== 10'h001) begin miscompares++; $display("FAIL read_cap got %h exp 001", rdata0); end
      bus_write(3'd4, 10'h001);
      vectors++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin miscompares++; $display("FAIL cap_clear got %b/%b exp 0", irq0, irq2); end
   endtask

   task automatic test_clear_collision();
      in_port[3] = 1'b1;
      tick();  // E0
      tick();  // E1
      bus_write(3'd4, 10'h008);  // sampled at E2, same edge as the capture
      bus_read(3'd4);
      vectors++; if (rdata0 !== 10'h008 || rdata2 !== 10'h008) begin miscompares++; $display("FAIL collision got %h/%h exp 008", rdata0, rdata2); end
   endtask

   task automatic test_mask_any();
      bus_write(3'd3, 10'h000);
      bus_write(3'd4, 10'h3FF);
      in_port[5] = 1'b1; tick(); tick();
      in_port[5] = 1'b0; tick(); tick();
      tick(); tick();
      vectors++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin miscompares++; $display("FAIL masked_irq got %b/%b exp 0", irq0, irq2); end
      bus_read(3'd4);
      vectors++; if (rdata2 !== 10'h020 || rdata0 !== 10'h020) begin miscompares++; $display("FAIL any_cap got %h/%h exp 020", rdata2, rdata0); end
      bus_write(3'd3, 10'h020);
      vectors++; if (irq2 !== 1'b1 || irq0 !== 1'b1) begin miscompares++; $display("FAIL unmask_irq got %b/%b exp 1", irq2, irq0); end
   endtask

   task automatic test_reserved();
      bus_write(3'd6, 10'h3FF);
      vectors++; if (out0 !== 10'h0C3) begin miscompares++; $display("FAIL reserved_wr got %h exp 0C3", out0); end
      bus_read(3'd6);
      vectors++; if (rdata0 !== '0) begin miscompares++; $display("FAIL reserved_rd got %h exp 000", rdata0); end
      bus_read(3'd3);
      vectors++; if (rdata0 !== 10'h020) begin miscompares++; $display("FAIL reserved_mask got %h exp 020", rdata0); end
      bus_read(3'd4);
      vectors++; if (rdata2 !== 10'h020) begin miscompares++; $display("FAIL reserved_cap got %h exp 020", rdata2); end
   endtask

   task automatic test_reset_release();
      in_port = 10'h3FF;
      reset = 1'b1;
      repeat (4) tick();
      reset = 1'b0;
      bus_write(3'd3, 10'h3FF);
      repeat (3) tick();
      vectors++; if (irq0 !== 1'b0 || irq2 !== 1'b0) begin miscompares++; $display("FAIL release_irq got %b/%b exp 0", irq0, irq2); end
      bus_read(3'd4);
      vectors++; if (rdata0 !== '0 || rdata2 !== '0) begin miscompares++; $display("FAIL release_cap got %h/%h exp 000", rdata0, rdata2); end
      vectors++; if (out0 !== RV) begin miscompares++; $display("FAIL release_out got %h exp %h", out0, RV); end
   endtask

   task automatic test_random();
      logic [W-1:0] flip;
      for (int n = 0; n < 600; n++) begin
         reset      = ($urandom_range(0, 59) == 0);
         chipselect = 1'($urandom);
         write_n    = 1'($urandom);
         read_n     = 1'($urandom);
         address    = 3'($urandom);
         writedata  = 10'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            flip = '0;
            flip[$urandom_range(0, W-1)] = 1'b1;
            in_port = in_port ^ flip;
         end
         tick();
         vectors++; if (out0 !== out_m || out2 !== out_m) begin miscompares++; $display("FAIL rnd_out cyc %0d got %h/%h exp %h", n, out0, out2, out_m); end
         vectors++; if (irq0 !== |(cap0_m & mask_m)) begin miscompares++; $display("FAIL rnd_irq0 cyc %0d got %b exp %b", n, irq0, |(cap0_m & mask_m)); end
         vectors++; if (irq2 !== |(cap2_m & mask_m)) begin miscompares++; $display("FAIL rnd_irq2 cyc %0d got %b exp %b", n, irq2, |(cap2_m & mask_m)); end
         vectors++; if (rdata0 !== rd0_m) begin miscompares++; $display("FAIL rnd_rdata0 cyc %0d got %h exp %h", n, rdata0, rd0_m); end
         vectors++; if (rdata2 !== rd2_m) begin miscompares++; $display("FAIL rnd_rdata2 cyc %0d got %h exp %h", n, rdata2, rd2_m); end
      end
      chipselect = 1'b0; reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i <= S; i++) hist.push_back('0);
      out_m = RV; mask_m = '0; cap0_m = '0; cap2_m = '0; rd0_m = '0; rd2_m = '0;
      test_reset();
      test_set_clear();
      test_rising_edge();
      test_clear_collision();
      test_mask_any();
      test_reserved();
      test_reset_release();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
